restoring_divider7: RTL

RESTORING_DIVIDER7 -- requirements
Module: restoring_divider7

---
 rtl/restoring_divider7_pkg.sv | 18 +
 rtl/restoring_divider7_subtractor8.sv | 49 ++++
 rtl/restoring_divider7.sv | 118 +++++++++++
 3 files changed

// File: rtl/restoring_divider7_pkg.sv
// Shared constants and state encoding for the 7-bit restoring divider.
//   WIDTH_C         : operand / quotient / remainder width
//   ITER_C          : number of restoring steps per division
//   DIV0_QUOTIENT_C : quotient reported when the divisor is zero
//   state_t         : controller states (IDLE, RUN, DONE)
package restoring_divider7_pkg;

  localparam int unsigned WIDTH_C = 7;
  localparam int unsigned ITER_C  = 7;
  localparam logic [WIDTH_C-1:0] DIV0_QUOTIENT_C = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_divider7_subtractor8.sv
// 8-bit subtractor diff = a - b with look-ahead borrow.
// Every internal borrow is formed directly as a sum of products of the
// per-bit generate/propagate terms, so there is no borrow ripple chain.
// Ports:
//   a, b       : 8-bit unsigned operands
//   diff       : a - b modulo 256
//   borrow_out : 1 when a < b
module borrow_look_ahead_subtractor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       borrow_out
);

  logic [7:0] gen;   // bit generates a borrow: a=0, b=1
  logic [7:0] prop;  // bit passes an incoming borrow: a==b
  logic [8:0] brw;   // brw[i] = borrow into bit i

  always_comb begin
    gen  = ~a & b;
    prop = ~(a ^ b);
  end

  // brw[i] = OR over j<i of ( gen[j] AND prop[j+1] .. prop[i-1] )
  always_comb begin
    logic acc;
    logic term;
    brw    = '0;
    acc    = 1'b0;
    term   = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      acc = 1'b0;
      for (int unsigned j = 0; j < i; j++) begin
        term = gen[j];
        for (int unsigned k = j + 1; k < i; k++) begin
          term = term & prop[k];
        end
        acc = acc | term;
      end
      brw[i] = acc;
    end
  end

  always_comb begin
    diff       = a ^ b ^ brw[7:0];
    borrow_out = brw[8];
  end

endmodule

// File: rtl/restoring_divider7.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : division request, sampled only while idle
//   dividend    : unsigned numerator, captured on the accepting edge
//   divisor     : unsigned denominator, captured on the accepting edge
//   busy        : high while a division is in progress or completing
//   done        : one-cycle pulse, results valid
//   quotient    : registered quotient (7'h7F on divide by zero)
//   remainder   : registered remainder (dividend on divide by zero)
//   div_by_zero : registered flag, last accepted divisor was zero
module restoring_divider7
  import restoring_divider7_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [2:0] LAST_STEP_C = 3'(ITER_C - 1);

  state_t           state, state_next;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] part;      // partial remainder
  logic [WIDTH-1:0] dvd_sh;    // dividend, consumed from the MSB
  logic [WIDTH-1:0] dsr;       // captured divisor
  logic [WIDTH-1:0] q_sh;      // quotient bits collected so far

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             q_bit;
  logic [WIDTH-1:0] part_step;
  logic             last_step;

  borrow_look_ahead_subtractor8 u_sub (
    .a          (trial),
    .b          ({1'b0, dsr}),
    .diff       (diff),
    .borrow_out (borrow)
  );

  always_comb begin
    state_next = state;
    trial      = {part, dvd_sh[WIDTH-1]};
    q_bit      = ~borrow;
    // Restore on borrow: keep the trial value instead of the difference.
    part_step  = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    last_step  = (cnt == LAST_STEP_C);
    case (state)
      IDLE: if (start) state_next = (divisor != '0) ? RUN : DONE;
      RUN:  if (last_step) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      part        <= '0;
      dvd_sh      <= '0;
      dsr         <= '0;
      q_sh        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dvd_sh      <= dividend;
              dsr         <= divisor;
              part        <= '0;
              q_sh        <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= DIV0_QUOTIENT_C;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          part   <= part_step;
          dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
          q_sh   <= {q_sh[WIDTH-2:0], q_bit};
          cnt    <= (cnt == 3'd7) ? cnt : cnt + 3'd1;
          // Visible results only change on the final step.
          if (last_step) begin
            quotient  <= {q_sh[WIDTH-2:0], q_bit};
            remainder <= part_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
